// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : cpu_pkg                                                        |
// | Purpose   : Shared definitions for the fetch, parse and execute stages:    |
// |             instruction width, field positions, opcode constants and the   |
// |             fetch-stage state encoding.                                    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package cpu_pkg;

   localparam int INSTR_W = 16;

   // Instruction field positions
   localparam int OPC_LSB  = 0;
   localparam int OPC_MSB  = 4;
   localparam int ROUT_LSB = 13;
   localparam int ROUT_MSB = 15;
   localparam int RA_LSB   = 10;
   localparam int RA_MSB   = 12;
   localparam int RB_LSB   = 7;
   localparam int RB_MSB   = 9;

   // Opcode constants
   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_BR  = 5'b10001;

   // Fetch state encoding
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   function automatic logic [4:0] op_field(input logic [INSTR_W-1:0] ir);
      return ir[OPC_MSB:OPC_LSB];
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : fetch_unit_if                                                  |
// | Purpose   : Bundles the instruction-memory read bus and the IR/retire      |
// |             handshake between fetch and the downstream stages.             |
// | Signals   : mem_req/mem_addr      fetch -> memory read request             |
// |             mem_rvalid/mem_rdata  memory -> fetch read data                |
// |             opcode/ir_valid/ir_pc fetch -> parser/execute IR contents      |
// |             ir_ack/br_taken/br_target execute -> fetch retire + redirect   |
// | Modports  : master (fetch side), slave (memory + execute side)             |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface fetch_unit_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_rvalid;
   logic [INSTR_W-1:0] mem_rdata;
   logic [INSTR_W-1:0] opcode;
   logic               ir_valid;
   logic [ADDR_W-1:0]  ir_pc;
   logic               ir_ack;
   logic               br_taken;
   logic [ADDR_W-1:0]  br_target;

   modport master (
      output mem_req, mem_addr, opcode, ir_valid, ir_pc,
      input  mem_rvalid, mem_rdata, ir_ack, br_taken, br_target
   );

   modport slave (
      input  mem_req, mem_addr, opcode, ir_valid, ir_pc,
      output mem_rvalid, mem_rdata, ir_ack, br_taken, br_target
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fetch_unit                                                     |
// | Purpose   : Instruction fetch stage. Owns the PC, issues word reads,       |
// |             latches the returned word into the IR and holds it until       |
// |             execute retires it, then fetches sequential or branch target.  |
// |             One instruction in flight, all outputs registered.             |
// | Ports     : CLK    system clock, rising edge                               |
// |             reset  synchronous active-high reset                           |
// |             run    fetch enable, examined only while idle                  |
// |             bus    fetch_unit_if.master (memory bus + IR handshake)        |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = cpu_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire           CLK,
   input  wire           reset,
   input  wire           run,
   fetch_unit_if.master  bus
);

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]  opcode_q, opcode_d;
   logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
   logic                ir_valid_q, ir_valid_d;
   logic                mem_req_q, mem_req_d;

   // State register
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, PC mux and datapath next values
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      opcode_d   = opcode_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      mem_req_d  = mem_req_q;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               mem_req_d = 1'b1;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            // mem_req is high throughout this state, so rvalid is trusted here
            if (bus.mem_rvalid) begin
               opcode_d   = bus.mem_rdata;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
               mem_req_d  = 1'b0;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            // br_taken only matters on the retiring cycle
            if (bus.ir_ack) begin
               ir_valid_d = 1'b0;
               mem_req_d  = 1'b1;
               pc_d       = bus.br_taken ? bus.br_target : pc_q + ADDR_W'(1);
               state_d    = S_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         opcode_q   <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         mem_req_q  <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         opcode_q   <= opcode_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         mem_req_q  <= mem_req_d;
      end
   end

   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = pc_q;
   assign bus.opcode   = opcode_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.ir_pc    = ir_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_fetch_unit                                                  |
// | Purpose   : Self-checking bench for fetch_unit: directed scenarios then a  |
// |             randomized instruction stream checked against a transaction-   |
// |             level model (expected PC sequence over a random memory image). |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

   localparam int AW = 8;
   localparam int IW = 16;

   logic CLK = 1'b0;
   logic reset;
   logic run;

   int vectors    = 0;
   int miscompares = 0;

   logic [IW-1:0] mem [256];
   logic [AW-1:0] exp_pc;
   logic [IW-1:0] exp_op;
   logic          taken;
   logic [AW-1:0] target;

   fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(8'h00)) dut (
      .CLK   (CLK),
      .reset (reset),
      .run   (run),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset          = 1'b1;
      run            = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      bus.ir_ack     = 1'b0;
      bus.br_taken   = 1'b0;
      bus.br_target  = '0;
      for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);

      // Reset state
      step(); step();
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_ir_valid", 32'(bus.ir_valid), 0);
      chk("rst_opcode", 32'(bus.opcode), 0);
      chk("rst_ir_pc", 32'(bus.ir_pc), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);

      // Release reset, idle without run
      reset = 1'b0;
      step();
      chk("idle_no_run_req", 32'(bus.mem_req), 0);

      // First fetch
      run = 1'b1;
      step();
      chk("first_req", 32'(bus.mem_req), 1);
      chk("first_addr", 32'(bus.mem_addr), 0);
      run = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h2C07;
      step();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      chk("first_opcode", 32'(bus.opcode), 32'h2C07);
      chk("first_ir_valid", 32'(bus.ir_valid), 1);
      chk("first_ir_pc", 32'(bus.ir_pc), 0);
      chk("first_req_low", 32'(bus.mem_req), 0);

      // br_taken without ir_ack is ignored
      bus.br_taken = 1'b1; bus.br_target = 8'h55;
      step(); step();
      chk("br_noack_addr", 32'(bus.mem_addr), 0);
      chk("br_noack_req", 32'(bus.mem_req), 0);
      chk("br_noack_valid", 32'(bus.ir_valid), 1);

      // Sequential retire
      bus.br_taken = 1'b0; bus.ir_ack = 1'b1;
      step();
      bus.ir_ack = 1'b0;
      chk("seq_req", 32'(bus.mem_req), 1);
      chk("seq_addr", 32'(bus.mem_addr), 1);
      chk("seq_ir_valid", 32'(bus.ir_valid), 0);
      chk("seq_opcode_kept", 32'(bus.opcode), 32'h2C07);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h1234;
      step();
      bus.mem_rvalid = 1'b0;
      chk("seq_ir_pc", 32'(bus.ir_pc), 1);
      chk("seq_opcode", 32'(bus.opcode), 32'h1234);

      // Taken branch
      bus.ir_ack = 1'b1; bus.br_taken = 1'b1; bus.br_target = 8'h40;
      step();
      bus.ir_ack = 1'b0; bus.br_taken = 1'b0;
      chk("br_addr", 32'(bus.mem_addr), 32'h40);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hBEEF;
      step();
      bus.mem_rvalid = 1'b0;
      chk("br_ir_pc", 32'(bus.ir_pc), 32'h40);

      // PC wrap at 0xFF
      bus.ir_ack = 1'b1; bus.br_taken = 1'b1; bus.br_target = 8'hFF;
      step();
      bus.ir_ack = 1'b0; bus.br_taken = 1'b0;
      chk("wrap_pre_addr", 32'(bus.mem_addr), 32'hFF);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h0F0F;
      step();
      bus.mem_rvalid = 1'b0;
      chk("wrap_ir_pc", 32'(bus.ir_pc), 32'hFF);
      bus.ir_ack = 1'b1;
      step();
      bus.ir_ack = 1'b0;
      chk("wrap_addr", 32'(bus.mem_addr), 0);
      chk("wrap_req", 32'(bus.mem_req), 1);

      // Memory stall of 5 cycles with ir_ack pulses
      for (int i = 0; i < 5; i++) begin
         bus.ir_ack   = i[0];
         bus.br_taken = 1'b1; bus.br_target = 8'h77;
         step();
         chk("stall_req", 32'(bus.mem_req), 1);
         chk("stall_addr", 32'(bus.mem_addr), 0);
         chk("stall_valid", 32'(bus.ir_valid), 0);
      end
      bus.ir_ack = 1'b0; bus.br_taken = 1'b0;

      // Reset while waiting, then a stale rvalid
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hFFFF;
      step();
      bus.mem_rvalid = 1'b0;
      chk("stale_valid", 32'(bus.ir_valid), 0);
      chk("stale_opcode", 32'(bus.opcode), 0);
      chk("stale_req", 32'(bus.mem_req), 0);
      step();
      chk("stale_req2", 32'(bus.mem_req), 0);
      chk("stale_addr", 32'(bus.mem_addr), 0);

      // Randomized instruction stream against the memory image
      run = 1'b1;
      step();
      chk("rnd_start_req", 32'(bus.mem_req), 1);
      exp_pc = 8'h00;
      exp_op = '0;
      for (int n = 0; n < 60; n++) begin
         int stall, hold;
         stall = int'($urandom_range(0, 4));
         for (int s = 0; s < stall; s++) begin
            run          = 1'($urandom);
            bus.ir_ack   = 1'($urandom);
            bus.br_taken = 1'($urandom);
            bus.br_target = AW'($urandom);
            step();
            chk("rnd_stall_req", 32'(bus.mem_req), 1);
            chk("rnd_stall_addr", 32'(bus.mem_addr), 32'(exp_pc));
            chk("rnd_stall_valid", 32'(bus.ir_valid), 0);
         end
         bus.ir_ack = 1'b0; bus.br_taken = 1'b0;
         bus.mem_rvalid = 1'b1; bus.mem_rdata = mem[exp_pc];
         step();
         bus.mem_rvalid = 1'b0;
         exp_op = mem[exp_pc];
         chk("rnd_opcode", 32'(bus.opcode), 32'(exp_op));
         chk("rnd_ir_pc", 32'(bus.ir_pc), 32'(exp_pc));
         chk("rnd_ir_valid", 32'(bus.ir_valid), 1);
         chk("rnd_req_low", 32'(bus.mem_req), 0);
         hold = int'($urandom_range(0, 3));
         for (int h = 0; h < hold; h++) begin
            run            = 1'($urandom);
            bus.br_taken   = 1'($urandom);
            bus.br_target  = AW'($urandom);
            bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata  = IW'($urandom);
            step();
            chk("rnd_hold_opcode", 32'(bus.opcode), 32'(exp_op));
            chk("rnd_hold_valid", 32'(bus.ir_valid), 1);
            chk("rnd_hold_req", 32'(bus.mem_req), 0);
            chk("rnd_hold_addr", 32'(bus.mem_addr), 32'(exp_pc));
         end
         bus.mem_rvalid = 1'b0;
         taken  = 1'($urandom);
         target = ($urandom_range(0, 7) == 0) ? exp_pc : AW'($urandom);
         bus.ir_ack = 1'b1; bus.br_taken = taken; bus.br_target = target;
         step();
         bus.ir_ack = 1'b0; bus.br_taken = 1'b0;
         exp_pc = taken ? target : AW'((int'(exp_pc) + 1) % 256);
         chk("rnd_ack_req", 32'(bus.mem_req), 1);
         chk("rnd_ack_addr", 32'(bus.mem_addr), 32'(exp_pc));
         chk("rnd_ack_valid", 32'(bus.ir_valid), 0);
         chk("rnd_ack_opcode", 32'(bus.opcode), 32'(exp_op));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
